// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - iB, one full-subtractor step per clock, LSB first.
// Latency WIDTH+1 edges from start to oValid; iStart is ignored (not queued) while busy.
module serial_subtractor #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 3
) (
   input  logic             iClk,
   input  logic             iRst,
   input  logic             iStart,
   input  logic [WIDTH-1:0] iData_a,
   input  logic [WIDTH-1:0] iData_b,
   input  logic             iB,
   output logic             oBusy,
   output logic             oValid,
   output logic [WIDTH-1:0] oData,
   output logic             oData_B
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             brw_q, brw_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic             data_b_q, data_b_d;

   logic             diff_bit;
   logic             brw_next;
   logic [WIDTH-1:0] res_next;

   // Single full-subtractor cell working on the current LSBs.
   always_comb begin
      diff_bit = a_q[0] ^ b_q[0] ^ brw_q;
      brw_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
      res_next = {diff_bit, res_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      brw_d    = brw_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      valid_d  = 1'b0;
      data_d   = data_q;
      data_b_d = data_b_q;

      case (state_q)
         IDLE, DONE: begin
            if (iStart) begin
               a_d     = iData_a;
               b_d     = iData_b;
               brw_d   = iB;
               res_d   = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = res_next;
            brw_d = brw_next;
            cnt_d = cnt_q + CNT_W'(1);
            // Last bit: publish result and borrow together.
            if (cnt_q == CNT_W'(WIDTH - 1)) begin
               data_d   = res_next;
               data_b_d = brw_next;
               valid_d  = 1'b1;
               busy_d   = 1'b0;
               state_d  = DONE;
            end
         end
         default: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q  <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         brw_q    <= 1'b0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= '0;
         data_b_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         brw_q    <= brw_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         data_q   <= data_d;
         data_b_q <= data_b_d;
      end
   end

   assign oBusy   = busy_q;
   assign oValid  = valid_q;
   assign oData   = data_q;
   assign oData_B = data_b_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed literal cases plus random traffic against a transaction-level model.
module tb_serial_subtractor;
   localparam int WIDTH = 8;
   localparam int CNT_W = 3;

   logic             iClk;
   logic             iRst;
   logic             iStart;
   logic [WIDTH-1:0] iData_a;
   logic [WIDTH-1:0] iData_b;
   logic             iB;
   logic             oBusy;
   logic             oValid;
   logic [WIDTH-1:0] oData;
   logic             oData_B;

   int checks   = 0;
   int failures = 0;

   serial_subtractor #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .iClk(iClk), .iRst(iRst), .iStart(iStart),
      .iData_a(iData_a), .iData_b(iData_b), .iB(iB),
      .oBusy(oBusy), .oValid(oValid), .oData(oData), .oData_B(oData_B)
   );

   initial begin
      iClk = 1'b0;
      forever #5 iClk = ~iClk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: an accepted request occupies the unit for WIDTH edges,
   // then its arithmetic result is presented for one cycle.
   bit               m_init = 0;
   int               m_left = 0;
   bit               m_valid = 0;
   logic [WIDTH-1:0] m_data = '0;
   logic             m_bor = 1'b0;
   logic [WIDTH:0]   m_pending = '0;

   always @(posedge iClk) begin
      if (iRst) begin
         m_init  = 1;
         m_left  = 0;
         m_valid = 0;
         m_data  = '0;
         m_bor   = 1'b0;
      end else begin
         m_valid = 0;
         if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
               m_valid = 1;
               {m_bor, m_data} = m_pending;
            end
         end else if (iStart) begin
            m_pending = {1'b0, iData_a} - {1'b0, iData_b} - {{WIDTH{1'b0}}, iB};
            m_left    = WIDTH;
         end
      end
   end

   always @(negedge iClk) begin
      if (m_init) begin
         check("model_busy",   {31'd0, oBusy},   {31'd0, m_left > 0});
         check("model_valid",  {31'd0, oValid},  {31'd0, m_valid});
         check("model_data",   {24'd0, oData},   {24'd0, m_data});
         check("model_borrow", {31'd0, oData_B}, {31'd0, m_bor});
      end
   end

   // Called at a negedge; issues a start and waits for the result with a cycle budget.
   task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input logic [7:0] exp_d, input logic exp_b, input bit poke);
      int k;
      int busy_cnt;
      bit seen;
      iStart  = 1'b1;
      iData_a = a;
      iData_b = b;
      iB      = bi;
      busy_cnt = 0;
      seen     = 0;
      for (k = 1; k <= 20; k++) begin
         @(negedge iClk);
         iStart  = 1'b0;
         iData_a = WIDTH'($urandom);
         iData_b = WIDTH'($urandom);
         iB      = 1'($urandom);
         if (poke && (k == 3 || k == 5)) iStart = 1'b1;
         if (oBusy) busy_cnt++;
         if (oValid) begin
            seen = 1;
            iStart = 1'b0;
            break;
         end
      end
      if (!seen) begin
         check({name, "_timeout"}, 32'd0, 32'd1);
      end else begin
         check({name, "_latency"}, k - 1, 32'd8);
         check({name, "_busy_cycles"}, busy_cnt, 32'd8);
         check({name, "_data"}, {24'd0, oData}, {24'd0, exp_d});
         check({name, "_borrow"}, {31'd0, oData_B}, {31'd0, exp_b});
      end
   endtask

   initial begin
      bit saw_valid;
      iRst = 1'b1; iStart = 1'b0; iData_a = '0; iData_b = '0; iB = 1'b0;
      repeat (2) @(negedge iClk);
      iRst = 1'b0;
      repeat (3) @(negedge iClk);
      check("reset_busy",   {31'd0, oBusy},   32'd0);
      check("reset_valid",  {31'd0, oValid},  32'd0);
      check("reset_data",   {24'd0, oData},   32'd0);
      check("reset_borrow", {31'd0, oData_B}, 32'd0);

      run_op("sub_03_01", 8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 0);
      @(negedge iClk);
      check("hold_after_done", {24'd0, oData}, 32'h02);
      run_op("sub_44_21_b", 8'h44, 8'h21, 1'b1, 8'h22, 1'b0, 0);
      run_op("sub_03_80_b", 8'h03, 8'h80, 1'b1, 8'h82, 1'b1, 0);  // accepted in DONE
      repeat (2) @(negedge iClk);
      run_op("sub_00_00_b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 0);
      run_op("sub_FF_FF",   8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 0);
      @(negedge iClk);
      run_op("ignore_start", 8'h10, 8'h05, 1'b0, 8'h0B, 1'b0, 1);
      run_op("back_to_back", 8'h05, 8'h10, 1'b0, 8'hF5, 1'b1, 0);

      // Reset in the middle of a run aborts it silently.
      iStart = 1'b1; iData_a = 8'h55; iData_b = 8'h11; iB = 1'b0;
      @(negedge iClk);
      iStart = 1'b0;
      repeat (3) @(negedge iClk);
      iRst = 1'b1;
      @(negedge iClk);
      iRst = 1'b0;
      check("abort_busy",   {31'd0, oBusy},   32'd0);
      check("abort_valid",  {31'd0, oValid},  32'd0);
      check("abort_data",   {24'd0, oData},   32'd0);
      check("abort_borrow", {31'd0, oData_B}, 32'd0);
      saw_valid = 0;
      repeat (12) begin
         @(negedge iClk);
         if (oValid) saw_valid = 1;
      end
      check("abort_no_valid", {31'd0, saw_valid}, 32'd0);
      run_op("after_abort", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0, 0);

      // Random traffic: frequent starts (many land while busy), rare resets.
      repeat (3000) begin
         @(negedge iClk);
         iStart  = ($urandom_range(0, 2) == 0);
         iData_a = WIDTH'($urandom);
         iData_b = WIDTH'($urandom);
         iB      = 1'($urandom);
         iRst    = ($urandom_range(0, 399) == 0);
      end
      @(negedge iClk);
      iRst = 1'b0; iStart = 1'b0;
      repeat (12) @(negedge iClk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
